// File: rtl/drac_pkg.sv
// Shared fetch-stage types and defaults: fetch-queue entry layout, reset PC, queue depth.
package drac_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_0000_0100;
  localparam int unsigned     FQ_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            pred_taken;
    logic [XLEN-1:0] pred_addr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched instructions between the icache response and decode.
module fetch_queue
  import drac_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  fq_entry_t                     entry_i,
  input  logic                          pop_i,
  output logic                          valid_o,
  output fq_entry_t                     head_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  assign do_pop = pop_i && (count_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generation, single-outstanding icache request control and fetch queue.
module fetch_pc_gen
  import drac_pkg::*;
#(
  parameter logic [63:0] RESET_PC_P = drac_pkg::RESET_PC,
  parameter int unsigned FQ_DEPTH_P = drac_pkg::FQ_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [63:0] pc_fetch_o,
  input  logic        bp_is_branch_i,
  input  logic        bp_taken_i,
  input  logic [63:0] bp_addr_i,
  output logic        icache_req_valid_o,
  input  logic        icache_req_ready_i,
  input  logic        icache_resp_valid_i,
  input  logic [31:0] icache_resp_instr_i,
  input  logic        ex_redirect_i,
  input  logic [63:0] ex_redirect_addr_i,
  input  logic        csr_redirect_i,
  input  logic [63:0] csr_redirect_addr_i,
  output logic        fq_valid_o,
  input  logic        fq_ready_i,
  output logic [63:0] fq_pc_o,
  output logic [31:0] fq_instr_o,
  output logic        fq_pred_taken_o,
  output logic [63:0] fq_pred_addr_o
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH_P) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [63:0] ALIGN_MASK = ~64'h3;

  logic [63:0]      pc_q;
  logic             inflight_q;
  logic             kill_q;
  logic [63:0]      infl_pc_q;
  logic             infl_pred_taken_q;
  logic [63:0]      infl_pred_addr_q;

  logic             redirect;
  logic [63:0]      redirect_pc;
  logic             pred_taken;
  logic [OCC_W-1:0] occupancy;
  logic             accept;
  logic             resp;
  logic             push;
  logic [CNT_W-1:0] fq_count;
  fq_entry_t        push_entry;
  fq_entry_t        head;

  assign redirect    = csr_redirect_i | ex_redirect_i;
  assign redirect_pc = (csr_redirect_i ? csr_redirect_addr_i : ex_redirect_addr_i) & ALIGN_MASK;
  assign pred_taken  = bp_is_branch_i & bp_taken_i;

  // The outstanding request reserves a queue slot so its response always has room.
  assign occupancy          = OCC_W'(fq_count) + OCC_W'(inflight_q);
  assign icache_req_valid_o = !rst_i && !redirect && !inflight_q
                              && (occupancy < OCC_W'(FQ_DEPTH_P));
  assign accept             = icache_req_valid_o && icache_req_ready_i;
  assign resp               = icache_resp_valid_i && inflight_q;
  assign push               = resp && !kill_q && !redirect;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q              <= RESET_PC_P;
      inflight_q        <= 1'b0;
      kill_q            <= 1'b0;
      infl_pc_q         <= '0;
      infl_pred_taken_q <= 1'b0;
      infl_pred_addr_q  <= '0;
    end else begin
      if (redirect)    pc_q <= redirect_pc;
      else if (accept) pc_q <= pred_taken ? (bp_addr_i & ALIGN_MASK) : pc_q + 64'd4;

      if (accept)    inflight_q <= 1'b1;
      else if (resp) inflight_q <= 1'b0;

      // A redirect while waiting marks the eventual response as stale.
      if (resp)                        kill_q <= 1'b0;
      else if (redirect && inflight_q) kill_q <= 1'b1;

      if (accept) begin
        infl_pc_q         <= pc_q;
        infl_pred_taken_q <= pred_taken;
        infl_pred_addr_q  <= bp_addr_i;
      end
    end
  end

  always_comb begin
    push_entry            = '0;
    push_entry.pc         = infl_pc_q;
    push_entry.instr      = icache_resp_instr_i;
    push_entry.pred_taken = infl_pred_taken_q;
    push_entry.pred_addr  = infl_pred_addr_q;
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH_P)
  ) u_fetch_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (fq_ready_i),
    .valid_o (fq_valid_o),
    .head_o  (head),
    .count_o (fq_count)
  );

  assign pc_fetch_o      = pc_q;
  assign fq_pc_o         = head.pc;
  assign fq_instr_o      = head.instr;
  assign fq_pred_taken_o = head.pred_taken;
  assign fq_pred_addr_o  = head.pred_addr;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: sequential fetch, prediction, backpressure, redirects, reset, wrap.
module tb_fetch_pc_gen;
  import drac_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] pc_fetch_o;
  logic        bp_is_branch_i, bp_taken_i;
  logic [63:0] bp_addr_i;
  logic        icache_req_valid_o, icache_req_ready_i;
  logic        icache_resp_valid_i;
  logic [31:0] icache_resp_instr_i;
  logic        ex_redirect_i, csr_redirect_i;
  logic [63:0] ex_redirect_addr_i, csr_redirect_addr_i;
  logic        fq_valid_o, fq_ready_i;
  logic [63:0] fq_pc_o, fq_pred_addr_o;
  logic [31:0] fq_instr_o;
  logic        fq_pred_taken_o;

  fetch_pc_gen dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .pc_fetch_o          (pc_fetch_o),
    .bp_is_branch_i      (bp_is_branch_i),
    .bp_taken_i          (bp_taken_i),
    .bp_addr_i           (bp_addr_i),
    .icache_req_valid_o  (icache_req_valid_o),
    .icache_req_ready_i  (icache_req_ready_i),
    .icache_resp_valid_i (icache_resp_valid_i),
    .icache_resp_instr_i (icache_resp_instr_i),
    .ex_redirect_i       (ex_redirect_i),
    .ex_redirect_addr_i  (ex_redirect_addr_i),
    .csr_redirect_i      (csr_redirect_i),
    .csr_redirect_addr_i (csr_redirect_addr_i),
    .fq_valid_o          (fq_valid_o),
    .fq_ready_i          (fq_ready_i),
    .fq_pc_o             (fq_pc_o),
    .fq_instr_o          (fq_instr_o),
    .fq_pred_taken_o     (fq_pred_taken_o),
    .fq_pred_addr_o      (fq_pred_addr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Predictor table (one entry) and icache model state
  logic [63:0] tab_pc, tab_tgt;
  logic        tab_br, tab_tk;
  logic        auto_resp, outstanding, last_acc;
  logic [63:0] acc_pc, out_pc;
  logic [63:0] issued_q [$];
  fq_entry_t   drained_q [$];
  int          n;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h1357_9BDF;
  endfunction

  // One clock: drive predictor, record accept/pop, advance, then drive the icache response.
  task automatic tick();
    fq_entry_t e;
    #1;
    bp_is_branch_i = (pc_fetch_o == tab_pc) && tab_br;
    bp_taken_i     = (pc_fetch_o == tab_pc) && tab_tk;
    bp_addr_i      = tab_tgt;
    #1;
    last_acc = icache_req_valid_o && icache_req_ready_i;
    if (last_acc) begin
      issued_q.push_back(pc_fetch_o);
      acc_pc = pc_fetch_o;
    end
    if (fq_valid_o && fq_ready_i && !ex_redirect_i && !csr_redirect_i && !rst_i) begin
      e.pc = fq_pc_o; e.instr = fq_instr_o;
      e.pred_taken = fq_pred_taken_o; e.pred_addr = fq_pred_addr_o;
      drained_q.push_back(e);
    end
    if (icache_resp_valid_i) check("resp_has_inflight", 64'(dut.inflight_q), 64'd1);
    @(posedge clk_i);
    #1;
    if (last_acc) begin
      outstanding = 1'b1;
      out_pc = acc_pc;
    end
    if (auto_resp && outstanding) begin
      icache_resp_valid_i = 1'b1;
      icache_resp_instr_i = instr_of(out_pc);
      outstanding = 1'b0;
    end else begin
      icache_resp_valid_i = 1'b0;
    end
  endtask

  task automatic wait_acc(input string tag);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    check(tag, 64'(last_acc), 64'd1);
  endtask

  task automatic wait_drain(input string tag, input int target);
    for (int i = 0; i < 30; i++) begin
      if (drained_q.size() >= target) break;
      tick();
    end
    check(tag, 64'(drained_q.size() >= target), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    bp_is_branch_i = 0; bp_taken_i = 0; bp_addr_i = '0;
    icache_req_ready_i = 1'b1; icache_resp_valid_i = 1'b0; icache_resp_instr_i = '0;
    ex_redirect_i = 0; ex_redirect_addr_i = '0; csr_redirect_i = 0; csr_redirect_addr_i = '0;
    fq_ready_i = 1'b0;
    tab_pc = 64'h1; tab_tgt = '0; tab_br = 0; tab_tk = 0;
    auto_resp = 1'b1; outstanding = 1'b0; last_acc = 1'b0; acc_pc = '0; out_pc = '0;

    // Reset
    @(posedge clk_i); #1;
    check("rst_req_valid", 64'(icache_req_valid_o), 64'd0);
    check("rst_pc", pc_fetch_o, 64'h100);
    check("rst_fq_valid", 64'(fq_valid_o), 64'd0);
    tick();
    rst_i = 1'b0;

    // Sequential fetch and taken prediction at 0x108
    tab_pc = 64'h108; tab_br = 1; tab_tk = 1; tab_tgt = 64'h2000;
    repeat (6) tick();
    check("seq_issued_cnt", 64'(issued_q.size()), 64'd3);
    check("seq_pc0", issued_q[0], 64'h100);
    check("seq_pc1", issued_q[1], 64'h104);
    check("seq_pc2", issued_q[2], 64'h108);
    check("pred_next_pc", pc_fetch_o, 64'h2000);

    // Taken without is_branch is not a prediction
    tab_pc = 64'h2000; tab_br = 0; tab_tk = 1; tab_tgt = 64'h5550;
    tick();
    check("nobr_next_pc", pc_fetch_o, 64'h2004);

    // Backpressure: queue holds FQ_DEPTH entries and stops issuing
    repeat (6) tick();
    check("full_issued_cnt", 64'(issued_q.size()), 64'd4);
    check("full_req_valid", 64'(icache_req_valid_o), 64'd0);
    check("full_head_pc", fq_pc_o, 64'h100);
    fq_ready_i = 1'b1;
    wait_drain("drain_done", 4);
    check("drain0_pc", drained_q[0].pc, 64'h100);
    check("drain0_instr", 64'(drained_q[0].instr), 64'(instr_of(64'h100)));
    check("drain1_pc", drained_q[1].pc, 64'h104);
    check("drain2_pc", drained_q[2].pc, 64'h108);
    check("drain2_pred", 64'(drained_q[2].pred_taken), 64'd1);
    check("drain2_paddr", drained_q[2].pred_addr, 64'h2000);
    check("drain3_pc", drained_q[3].pc, 64'h2000);
    check("drain3_pred", 64'(drained_q[3].pred_taken), 64'd0);

    // Execute redirect with a request outstanding
    tab_pc = 64'h1;
    auto_resp = 1'b0;
    wait_acc("ex_wait_acc");
    ex_redirect_i = 1'b1; ex_redirect_addr_i = 64'h3002;
    #1;
    check("redir_req_gate", 64'(icache_req_valid_o), 64'd0);
    tick();
    ex_redirect_i = 1'b0;
    #1;
    check("ex_pc", pc_fetch_o, 64'h3000);
    check("ex_flush", 64'(fq_valid_o), 64'd0);
    check("ex_wait_inflight", 64'(icache_req_valid_o), 64'd0);
    icache_resp_valid_i = 1'b1; icache_resp_instr_i = 32'hDEAD_BEEF; outstanding = 1'b0;
    tick();
    check("late_resp_dropped", 64'(fq_valid_o), 64'd0);
    #1;
    check("ex_req_valid", 64'(icache_req_valid_o), 64'd1);
    check("ex_req_pc", pc_fetch_o, 64'h3000);
    auto_resp = 1'b1;
    n = drained_q.size();
    wait_drain("ex_drain", n + 1);
    check("ex_entry_pc", drained_q[n].pc, 64'h3000);
    check("ex_entry_instr", 64'(drained_q[n].instr), 64'(instr_of(64'h3000)));

    // CSR redirect wins over execute redirect
    csr_redirect_i = 1'b1; csr_redirect_addr_i = 64'h8000;
    ex_redirect_i  = 1'b1; ex_redirect_addr_i  = 64'h3000;
    tick();
    csr_redirect_i = 1'b0; ex_redirect_i = 1'b0;
    #1;
    check("csr_pc", pc_fetch_o, 64'h8000);
    check("csr_flush", 64'(fq_valid_o), 64'd0);
    wait_acc("csr_wait_acc");
    check("csr_issue_pc", issued_q[$], 64'h8000);

    // Reset mid-stream with a request outstanding
    auto_resp = 1'b0;
    wait_acc("rst_wait_acc");
    rst_i = 1'b1;
    #1;
    check("rst_mid_req_valid", 64'(icache_req_valid_o), 64'd0);
    icache_resp_valid_i = 1'b1; icache_resp_instr_i = 32'h0000_0BAD; outstanding = 1'b0;
    tick();
    rst_i = 1'b0;
    icache_req_ready_i = 1'b0;
    #1;
    check("rst_mid_pc", pc_fetch_o, 64'h100);
    check("rst_mid_fq", 64'(fq_valid_o), 64'd0);
    check("rst_mid_req", 64'(icache_req_valid_o), 64'd1);
    tick();
    check("rst_stale_drop", 64'(fq_valid_o), 64'd0);

    // PC wrap at top of address space
    icache_req_ready_i = 1'b1; auto_resp = 1'b1;
    ex_redirect_i = 1'b1; ex_redirect_addr_i = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    ex_redirect_i = 1'b0;
    n = drained_q.size();
    #1;
    check("wrap_pc", pc_fetch_o, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_acc("wrap_wait_acc");
    check("wrap_issue_pc", issued_q[$], 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_next_pc", pc_fetch_o, 64'h0);
    wait_drain("wrap_drain", n + 1);
    check("wrap_entry_pc", drained_q[n].pc, 64'hFFFF_FFFF_FFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
